// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern sequencer: mode and bounce-direction enums,
// plus the initial value each pattern starts from.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_BLINK  = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    localparam logic [7:0] INIT_BLINK  = 8'h00;
    localparam logic [7:0] INIT_CHASE  = 8'h01;
    localparam logic [7:0] INIT_BOUNCE = 8'h01;
    localparam logic [7:0] INIT_FILL   = 8'h00;

    function automatic logic [7:0] init_led(input mode_t m);
        case (m)
            MODE_BLINK:  return INIT_BLINK;
            MODE_CHASE:  return INIT_CHASE;
            MODE_BOUNCE: return INIT_BOUNCE;
            default:     return INIT_FILL;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_seq_if.sv
// Board-side signals of the sequencer: raw button in, LED pattern and mode out.
interface led_pattern_seq_if;
    import led_pkg::*;

    logic       btn;
    logic [7:0] LED;
    logic [1:0] mode;

    modport master (output btn, input LED, input mode);
    modport slave  (input btn, output LED, output mode);

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability counter and rising-edge press pulse for a bouncy button.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic press
);
    localparam int            CW   = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

    logic [1:0]    sync;
    logic          sync_btn;
    logic          stable_btn;
    logic [CW-1:0] cnt;

    assign sync_btn = sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync       <= '0;
            stable_btn <= 1'b0;
            cnt        <= '0;
            press      <= 1'b0;
        end else begin
            sync  <= {sync[0], btn_in};
            press <= 1'b0;
            if (sync_btn == stable_btn) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                // accept the new level; only an accepted rise is a press
                stable_btn <= sync_btn;
                cnt        <= '0;
                press      <= sync_btn;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_pattern_seq.sv
// Four-mode LED pattern sequencer: a prescaler paces pattern steps, a debounced
// button advances the mode and restarts the pattern and prescaler.
module led_pattern_seq
    import led_pkg::*;
#(
    parameter int STEP_DIV     = 12_500_000,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic               clk,
    input  logic               rst,
    led_pattern_seq_if.slave   bus
);
    localparam int            PW   = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(STEP_DIV - 1);

    logic [PW-1:0] cnt, cnt_nx;
    mode_t         mode_q, mode_nx;
    dir_t          dir_q, dir_nx;
    logic [7:0]    led_q, led_nx;
    logic          press;
    logic          step_tick;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn_in (bus.btn),
        .press  (press)
    );

    assign step_tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            mode_q <= MODE_BLINK;
            dir_q  <= UP;
            led_q  <= INIT_BLINK;
        end else begin
            cnt    <= cnt_nx;
            mode_q <= mode_nx;
            dir_q  <= dir_nx;
            led_q  <= led_nx;
        end
    end

    always_comb begin
        cnt_nx  = step_tick ? '0 : cnt + 1'b1;
        mode_nx = mode_q;
        dir_nx  = dir_q;
        led_nx  = led_q;
        // a press restarts the pattern and swallows a coincident tick
        if (press) begin
            mode_nx = mode_t'(mode_q + 2'd1);
            led_nx  = init_led(mode_nx);
            dir_nx  = UP;
            cnt_nx  = '0;
        end else if (step_tick) begin
            case (mode_q)
                MODE_BLINK: led_nx = ~led_q;
                MODE_CHASE: led_nx = {led_q[6:0], led_q[7]};
                MODE_BOUNCE: begin
                    if (dir_q == UP) begin
                        led_nx = led_q << 1;
                        if (led_nx == 8'h80) dir_nx = DOWN;
                    end else begin
                        led_nx = led_q >> 1;
                        if (led_nx == 8'h01) dir_nx = UP;
                    end
                end
                default: led_nx = (led_q == 8'hFF) ? 8'h00 : {led_q[6:0], 1'b1};
            endcase
        end
    end

    assign bus.LED  = led_q;
    assign bus.mode = mode_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq with short step/debounce periods; a
// step-index reference model supplies expected LED/mode every cycle.
module tb_led_pattern_seq;
    localparam int SD = 4;
    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    led_pattern_seq_if bus();

    led_pattern_seq #(.STEP_DIV(SD), .DEBOUNCE_CYC(DC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial bus.btn = 1'b0;

    // Reference model: pattern value is a closed-form function of the step index k.
    int         m_ph = 0, m_k = 0, m_run = 0;
    bit         m_s1 = 0, m_s2 = 0, m_stab = 0, m_prs = 0, m_tick = 0, m_np = 0;
    logic [1:0] m_mode = 2'd0;
    logic [7:0] m_led = 8'h00;

    function automatic logic [7:0] pat(input logic [1:0] md, input int kk);
        int p;
        case (md)
            2'd0: return (kk % 2 == 1) ? 8'hFF : 8'h00;
            2'd1: return 8'(1 << (kk % 8));
            2'd2: begin
                p = kk % 14;
                return 8'(1 << ((p <= 7) ? p : 14 - p));
            end
            default: begin
                p = kk % 9;
                return 8'((1 << p) - 1);
            end
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ph = 0; m_k = 0; m_run = 0;
            m_s1 = 0; m_s2 = 0; m_stab = 0; m_prs = 0;
            m_mode = 2'd0;
        end else begin
            m_tick = (m_ph == SD - 1);
            if (m_prs) begin
                m_mode = m_mode + 2'd1;
                m_k = 0;
                m_ph = 0;
            end else begin
                if (m_tick) m_k++;
                m_ph = (m_ph + 1) % SD;
            end
            m_np = 0;
            if (m_s2 != m_stab) begin
                m_run++;
                if (m_run == DC) begin
                    m_stab = m_s2;
                    m_run = 0;
                    m_np = m_s2;
                end
            end else begin
                m_run = 0;
            end
            m_prs = m_np;
            m_s2 = m_s1;
            m_s1 = bus.btn;
        end
        m_led = pat(m_mode, m_k);
    end

    task automatic press_btn();
        logic [1:0] old;
        bit seen;
        old = bus.mode;
        seen = 0;
        bus.btn = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.mode !== old) seen = 1;
        end
        bus.btn = 1'b0;
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL press_timeout: mode stayed %0d, wanted a change within 20 cycles", bus.mode);
        end
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.btn = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.LED !== 8'h00 || bus.mode !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: LED=%h mode=%0d, want LED=00 mode=0", bus.LED, bus.mode);
        end
        rst = 1'b0;
    endtask

    task automatic test_blink();
        logic [7:0] prev;
        int changes, last_chg;
        bit bad_gap;
        prev = bus.LED;
        changes = 0;
        last_chg = 0;
        bad_gap = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.LED !== m_led || bus.mode !== m_mode) begin
                n_fail++;
                $display("FAIL blink_model cyc %0d: LED=%h mode=%0d, want LED=%h mode=%0d",
                         i, bus.LED, bus.mode, m_led, m_mode);
            end
            if (bus.LED !== prev) begin
                if (bus.LED !== ~prev || (changes > 0 && i - last_chg != SD)) bad_gap = 1;
                changes++;
                last_chg = i;
            end
            prev = bus.LED;
        end
        n_tests++;
        if (changes != 10 || bad_gap || bus.mode !== 2'd0) begin
            n_fail++;
            $display("FAIL blink_rate: changes=%0d bad_gap=%0d mode=%0d, want changes=10 bad_gap=0 mode=0",
                     changes, bad_gap, bus.mode);
        end
    endtask

    task automatic test_press();
        logic [1:0] old;
        int lat;
        old = bus.mode;
        lat = -1;
        bus.btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (lat < 0 && bus.mode !== old) lat = i;
        end
        bus.btn = 1'b0;
        n_tests++;
        if (lat < 1 || lat > DC + 4) begin
            n_fail++;
            $display("FAIL press_latency: latency=%0d, want 1..%0d", lat, DC + 4);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.LED !== m_led || bus.mode !== m_mode) begin
                n_fail++;
                $display("FAIL chase_model cyc %0d: LED=%h mode=%0d, want LED=%h mode=%0d",
                         i, bus.LED, bus.mode, m_led, m_mode);
            end
        end
        n_tests++;
        if (bus.mode !== 2'd1) begin
            n_fail++;
            $display("FAIL press_once: mode=%0d, want 1", bus.mode);
        end
    endtask

    task automatic test_glitch();
        logic [1:0] m0;
        m0 = bus.mode;
        for (int i = 0; i < 44; i++) begin
            if (i < 2) bus.btn = 1'b1;
            else if (i < 12) bus.btn = 1'b0;
            else if (i < 32) bus.btn = ((i - 12) / 2) % 2 == 0;
            else bus.btn = 1'b0;
            @(negedge clk);
            n_tests++;
            if (bus.LED !== m_led || bus.mode !== m_mode) begin
                n_fail++;
                $display("FAIL glitch_model cyc %0d: LED=%h mode=%0d, want LED=%h mode=%0d",
                         i, bus.LED, bus.mode, m_led, m_mode);
            end
        end
        n_tests++;
        if (bus.mode !== m0) begin
            n_fail++;
            $display("FAIL glitch_mode: mode=%0d, want %0d", bus.mode, m0);
        end
    endtask

    task automatic test_bounce();
        logic [7:0] seq [16];
        logic [1:0] emode [4];
        logic [7:0] eled [4];
        seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        emode = '{2'd3, 2'd0, 2'd1, 2'd2};
        eled  = '{8'h00, 8'h00, 8'h01, 8'h01};
        for (int j = 0; j < 4 && bus.mode !== 2'd1; j++) begin
            press_btn();
            settle();
        end
        press_btn();
        for (int i = 0; i < 16; i++) begin
            if (i > 0) repeat (SD) @(negedge clk);
            n_tests++;
            if (bus.LED !== seq[i] || bus.mode !== 2'd2) begin
                n_fail++;
                $display("FAIL bounce_seq step %0d: LED=%h mode=%0d, want LED=%h mode=2",
                         i, bus.LED, bus.mode, seq[i]);
            end
        end
        settle();
        for (int j = 0; j < 4; j++) begin
            press_btn();
            n_tests++;
            if (bus.mode !== emode[j] || bus.LED !== eled[j]) begin
                n_fail++;
                $display("FAIL mode_reload %0d: LED=%h mode=%0d, want LED=%h mode=%0d",
                         j, bus.LED, bus.mode, eled[j], emode[j]);
            end
            settle();
        end
    endtask

    task automatic test_coincide();
        for (int j = 0; j < 4 && bus.mode !== 2'd2; j++) begin
            press_btn();
            settle();
        end
        press_btn();
        // the press pulse lands on the cycle where the prescaler is at its last count
        repeat (9) @(negedge clk);
        bus.btn = 1'b1;
        repeat (6) @(negedge clk);
        n_tests++;
        if (bus.LED !== 8'h07 || bus.mode !== 2'd3) begin
            n_fail++;
            $display("FAIL coincide_pre: LED=%h mode=%0d, want LED=07 mode=3", bus.LED, bus.mode);
        end
        @(negedge clk);
        bus.btn = 1'b0;
        n_tests++;
        if (bus.LED !== 8'h00 || bus.mode !== 2'd0) begin
            n_fail++;
            $display("FAIL coincide_press: LED=%h mode=%0d, want LED=00 mode=0", bus.LED, bus.mode);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.LED !== 8'h00) begin
            n_fail++;
            $display("FAIL coincide_hold: LED=%h, want 00", bus.LED);
        end
        @(negedge clk);
        n_tests++;
        if (bus.LED !== 8'hFF || bus.mode !== 2'd0) begin
            n_fail++;
            $display("FAIL coincide_tick: LED=%h mode=%0d, want LED=FF mode=0", bus.LED, bus.mode);
        end
        settle();
    endtask

    task automatic test_reset_mid();
        logic [1:0] prev;
        int chg;
        for (int j = 0; j < 4 && bus.mode !== 2'd1; j++) begin
            press_btn();
            settle();
        end
        press_btn();
        repeat (40) @(negedge clk);
        bus.btn = 1'b1;
        n_tests++;
        if (bus.LED !== 8'h10 || bus.mode !== 2'd2) begin
            n_fail++;
            $display("FAIL reset_mid_pre: LED=%h mode=%0d, want LED=10 mode=2", bus.LED, bus.mode);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (bus.LED !== 8'h00 || bus.mode !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_mid: LED=%h mode=%0d, want LED=00 mode=0", bus.LED, bus.mode);
        end
        prev = bus.mode;
        chg = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.mode !== prev) chg++;
            prev = bus.mode;
            n_tests++;
            if (bus.LED !== m_led || bus.mode !== m_mode) begin
                n_fail++;
                $display("FAIL reset_mid_model cyc %0d: LED=%h mode=%0d, want LED=%h mode=%0d",
                         i, bus.LED, bus.mode, m_led, m_mode);
            end
        end
        n_tests++;
        if (chg != 1 || bus.mode !== 2'd1) begin
            n_fail++;
            $display("FAIL reset_mid_repress: changes=%0d mode=%0d, want changes=1 mode=1", chg, bus.mode);
        end
        bus.btn = 1'b0;
        settle();
    endtask

    task automatic test_random();
        int run;
        run = 0;
        for (int i = 0; i < 400; i++) begin
            if (run == 0) begin
                bus.btn = $urandom_range(0, 1);
                run = $urandom_range(1, 10);
            end
            run--;
            rst = ($urandom_range(0, 63) == 0);
            @(negedge clk);
            n_tests++;
            if (bus.LED !== m_led || bus.mode !== m_mode) begin
                n_fail++;
                $display("FAIL random_model cyc %0d: LED=%h mode=%0d, want LED=%h mode=%0d",
                         i, bus.LED, bus.mode, m_led, m_mode);
            end
        end
        rst = 1'b0;
        bus.btn = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_blink();
        test_press();
        test_glitch();
        test_bounce();
        test_coincide();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/led_pattern_seq.md
LED_PATTERN_SEQ -- requirements
Module: led_pattern_seq

Interface
REQ-001 The block SHALL have parameter STEP_DIV, default 12_500_000, giving clock cycles per pattern step (4 Hz at 50 MHz); legal range is 2 or more.
REQ-002 The block SHALL have parameter DEBOUNCE_CYC, default 1_000_000, giving the cycles btn must stay stable before it is accepted; legal range is 2 or more.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port btn, input, 1 bit: raw mode-advance pushbutton, asynchronous and bouncy, active-high.
REQ-006 The block SHALL have port LED, output, 8 bits: registered pattern that drives the board LEDs.
REQ-007 The block SHALL have port mode, output, 2 bits: current pattern mode, registered.

Function
REQ-008 Prescaler cnt SHALL count 0..STEP_DIV-1 and wrap; step_tick SHALL be high for exactly one cycle when cnt==STEP_DIV-1.
REQ-009 btn SHALL pass through a 2-flop synchronizer before any other use.
REQ-010 Debounce counter SHALL increment while sync_btn differs from stable_btn and clear to 0 when they are equal.
REQ-011 When the debounce counter reaches DEBOUNCE_CYC-1 while still differing, stable_btn SHALL take sync_btn and the counter SHALL clear.
REQ-012 press SHALL be a one-cycle pulse on each 0->1 transition of stable_btn; releases SHALL produce no pulse.
REQ-013 Modes SHALL be: 0 BLINK, 1 CHASE, 2 BOUNCE, 3 FILL.
REQ-014 On press, in the same cycle: mode SHALL become mode+1 mod 4, LED SHALL load the new mode's initial value, bounce dir SHALL become UP, and cnt SHALL become 0.
REQ-015 When press and step_tick coincide, press SHALL win and the tick SHALL be discarded.
REQ-016 Initial values SHALL be: BLINK 8'h00, CHASE 8'h01, BOUNCE 8'h01 with dir UP, FILL 8'h00.
REQ-017 BLINK: on each tick, LED SHALL become ~LED.
REQ-018 CHASE: on each tick, LED SHALL rotate left by 1, with 8'h80 becoming 8'h01.
REQ-019 BOUNCE states UP and DOWN: UP SHALL shift left, and when the result is 8'h80 dir SHALL become DOWN; DOWN SHALL shift right, and when the result is 8'h01 dir SHALL become UP. This gives a period of 14 ticks, each endpoint shown once.
REQ-020 FILL: on each tick, LED SHALL become {LED[6:0],1'b1}, and 8'hFF SHALL become 8'h00. This gives a period of 9 ticks.
REQ-021 Without ticks or presses, LED and mode SHALL hold their values.
REQ-022 LED SHALL change exactly 1 cycle after the tick or press that causes the change (registered output).

Reset
REQ-023 While rst is high at a clock edge, the block SHALL set: cnt=0, debounce counter=0, synchronizer and stable_btn=0, mode=0, LED=8'h00, dir=UP, press=0.
REQ-024 Reset SHALL override press and tick in the same cycle.
REQ-025 After reset mid-operation, a btn held high SHALL be re-debounced and SHALL produce exactly one press.

Structure
REQ-026 Shared package led_pkg SHALL hold the mode encodings (MODE_BLINK..MODE_FILL), the pattern initial values, and the dir encoding (UP/DOWN).
REQ-027 Debouncing (synchronizer, counter, stable_btn, press) SHALL be a sub-module named btn_debounce with ports clk, rst, btn_in, press.
REQ-028 The prescaler and pattern state machine SHALL reside in led_pattern_seq.

Verification (bench uses STEP_DIV=4, DEBOUNCE_CYC=4)
REQ-029 Reset, then run 40 cycles -> mode=0; LED toggles 00->FF->00 with one change every 4 cycles.
REQ-030 Clean press held for 10 cycles -> exactly one mode increment to 1 within DEBOUNCE_CYC+4 cycles; LED=01, then 02, 04 ... 80, 01 on successive ticks.
REQ-031 2-cycle btn glitch, and separately 0/1 toggling every 2 cycles for 20 cycles -> mode unchanged and LED sequence undisturbed.
REQ-032 Mode 2 for 16 ticks -> LED sequence 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01,02; then 4 presses -> mode 2->3->0->1->2, LED reloads 00, 00, 01, 01.
REQ-033 Press aligned so press and step_tick occur in the same cycle in FILL with LED=07 -> mode=0, LED=00 (tick dropped), next tick 4 cycles later -> LED=FF.
REQ-034 rst asserted for 1 cycle in BOUNCE DOWN with LED=10 while btn held high -> next cycle LED=00, mode=0; after debounce, mode=1 exactly once.
